pre_if_fetch_gen: RTL and testbench

Next-generation fetch-address generation stage in front of IF. It owns the fetch PC and arbitrates redirects (exception, eret, refetch, branch-resolve, BTB predict). It translates mapped addresses through the instruction TLB port over a configurable latency and issues multi-instruction fetch-block requests to the icache. Unlike the single-outstanding stage it replaces, it tracks up to MAX_OUTSTANDING in-flight requests and cancels stale responses after a redirect.

---
 rtl/pre_if_fetch_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_pre_if_fetch_gen.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_if_fetch_gen.sv
// Fetch-address generation in front of IF: owns the fetch PC, arbitrates redirects,
// translates mapped PCs through the ITLB port and keeps several icache requests in flight.
module pre_if_fetch_gen #(
  parameter logic [31:0] PC_START        = 32'hBFC00000,
  parameter int          FETCH_W         = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          TLB_LAT         = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exception_flush,
  input  logic [31:0] ex_addr,
  input  logic        eret_flush,
  input  logic [31:0] epc,
  input  logic        refetch_flush,
  input  logic [31:0] refetch_pc,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        IF_allowin,
  output logic        icache_valid,
  output logic [31:0] icache_addr,
  output logic        icache_uncached,
  input  logic        icache_addr_ok,
  input  logic        icache_data_ok,
  output logic [18:0] s0_vpn2,
  output logic        s0_odd_page,
  input  logic        s0_found,
  input  logic [19:0] s0_pfn,
  input  logic [2:0]  s0_c,
  input  logic        s0_v,
  input  logic [2:0]  k0,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [2:0]  fetch_cnt,
  output logic [2:0]  fetch_ex,
  output logic        rsp_discard
);

  localparam logic [1:0]  XLATE_IDLE = 2'd0;
  localparam logic [1:0]  LOOKUP     = 2'd1;
  localparam logic [1:0]  READY      = 2'd2;
  localparam logic [31:0] BLK_BYTES  = 32'(4 * FETCH_W);
  localparam logic [31:0] BLK_MASK   = BLK_BYTES - 32'd1;
  localparam logic [2:0]  MAX_OUT    = 3'(MAX_OUTSTANDING);
  localparam logic [2:0]  FW         = 3'(FETCH_W);
  localparam logic        LAT_LAST   = 1'(TLB_LAT - 1);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  state_q, state_d;
  logic        lat_q, lat_d;
  logic        hold_q, hold_d;
  logic [2:0]  out_q, out_d;
  logic [7:0]  disc_q, disc_d;
  logic        tlb_found_q, tlb_found_d;
  logic        tlb_v_q, tlb_v_d;
  logic [19:0] tlb_pfn_q, tlb_pfn_d;
  logic [2:0]  tlb_c_q, tlb_c_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [2:0]  fetch_cnt_q, fetch_cnt_d;
  logic [2:0]  fetch_ex_q, fetch_ex_d;

  logic        flush_s, mapped_s, adel_s, ready_s, issue_s, fire_s, take_ex_s;
  logic        dok_disc_s, dok_live_s, uncached_s;
  logic [31:0] flush_tgt_s, paddr_s, seq_pc_s;
  logic [2:0]  ex_s, slot_s, cnt_s, out_after_s;

  always_comb begin
    flush_s = exception_flush | eret_flush | refetch_flush | br_redirect;
    if (exception_flush) begin
      flush_tgt_s = ex_addr;
    end else if (eret_flush) begin
      flush_tgt_s = epc;
    end else if (refetch_flush) begin
      flush_tgt_s = refetch_pc;
    end else begin
      flush_tgt_s = br_target;
    end

    mapped_s = (pc_q[31:30] != 2'b10);
    adel_s   = (pc_q[1:0] != 2'b00);
    // Unmapped and misaligned PCs need no lookup, so they are ready straight from idle.
    ready_s  = resetn && !hold_q &&
               (((state_q == XLATE_IDLE) && (!mapped_s || adel_s)) || (state_q == READY));

    if (adel_s) begin
      ex_s = 3'b100;
    end else if (mapped_s && !tlb_found_q) begin
      ex_s = 3'b010;
    end else if (mapped_s && !tlb_v_q) begin
      ex_s = 3'b001;
    end else begin
      ex_s = 3'b000;
    end

    paddr_s    = mapped_s ? {tlb_pfn_q, pc_q[11:0]} : {3'b000, pc_q[28:0]};
    uncached_s = mapped_s ? (tlb_c_q != 3'd3) : (pc_q[29] | (k0 != 3'd3));
    slot_s     = 3'((pc_q & BLK_MASK) >> 2);
    cnt_s      = FW - slot_s;
    seq_pc_s   = (pc_q & ~BLK_MASK) + BLK_BYTES;

    issue_s   = ready_s && IF_allowin && (out_q < MAX_OUT) && !flush_s && (ex_s == 3'b000);
    fire_s    = issue_s && icache_addr_ok;
    take_ex_s = ready_s && IF_allowin && !flush_s && (ex_s != 3'b000);

    // Responses return in order, so cancelled ones are always consumed first.
    dok_disc_s  = icache_data_ok && (disc_q != 8'd0);
    dok_live_s  = icache_data_ok && (disc_q == 8'd0) && (out_q != 3'd0);
    out_after_s = out_q - {2'b00, dok_live_s} + {2'b00, fire_s};
  end

  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    lat_d       = lat_q;
    hold_d      = hold_q;
    tlb_found_d = tlb_found_q;
    tlb_v_d     = tlb_v_q;
    tlb_pfn_d   = tlb_pfn_q;
    tlb_c_d     = tlb_c_q;
    if (flush_s) begin
      pc_d    = flush_tgt_s;
      state_d = XLATE_IDLE;
      lat_d   = 1'b0;
      hold_d  = 1'b0;
      out_d   = 3'd0;
      disc_d  = disc_q - {7'd0, dok_disc_s} + {5'd0, out_after_s};
    end else begin
      out_d  = out_after_s;
      disc_d = disc_q - {7'd0, dok_disc_s};
      case (state_q)
        XLATE_IDLE: begin
          if (mapped_s && !adel_s) begin
            state_d = LOOKUP;
            lat_d   = 1'b0;
          end else begin
            state_d = XLATE_IDLE;
          end
        end
        LOOKUP: begin
          if (lat_q == LAT_LAST) begin
            state_d     = READY;
            tlb_found_d = s0_found;
            tlb_v_d     = s0_v;
            tlb_pfn_d   = s0_pfn;
            tlb_c_d     = s0_c;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        READY:   state_d = READY;
        default: state_d = XLATE_IDLE;
      endcase
      if (fire_s) begin
        pc_d    = pred_taken ? pred_target : seq_pc_s;
        state_d = XLATE_IDLE;
      end else if (take_ex_s) begin
        hold_d = 1'b1;
      end else begin
        hold_d = hold_q;
      end
    end

    fetch_valid_d = fire_s | take_ex_s;
    if (fire_s) begin
      fetch_pc_d  = pc_q;
      fetch_cnt_d = cnt_s;
      fetch_ex_d  = 3'b000;
    end else if (take_ex_s) begin
      fetch_pc_d  = pc_q;
      fetch_cnt_d = 3'd1;
      fetch_ex_d  = ex_s;
    end else begin
      fetch_pc_d  = fetch_pc_q;
      fetch_cnt_d = fetch_cnt_q;
      fetch_ex_d  = fetch_ex_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q          <= PC_START;
      state_q       <= XLATE_IDLE;
      lat_q         <= 1'b0;
      hold_q        <= 1'b0;
      out_q         <= 3'd0;
      disc_q        <= 8'd0;
      tlb_found_q   <= 1'b0;
      tlb_v_q       <= 1'b0;
      tlb_pfn_q     <= 20'd0;
      tlb_c_q       <= 3'd0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= 32'd0;
      fetch_cnt_q   <= 3'd0;
      fetch_ex_q    <= 3'd0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      lat_q         <= lat_d;
      hold_q        <= hold_d;
      out_q         <= out_d;
      disc_q        <= disc_d;
      tlb_found_q   <= tlb_found_d;
      tlb_v_q       <= tlb_v_d;
      tlb_pfn_q     <= tlb_pfn_d;
      tlb_c_q       <= tlb_c_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_cnt_q   <= fetch_cnt_d;
      fetch_ex_q    <= fetch_ex_d;
    end
  end

  assign icache_valid    = issue_s;
  assign icache_addr     = issue_s ? (paddr_s & ~BLK_MASK) : 32'd0;
  assign icache_uncached = issue_s & uncached_s;
  assign s0_vpn2         = (resetn && (state_q == LOOKUP)) ? pc_q[31:13] : 19'd0;
  assign s0_odd_page     = resetn && (state_q == LOOKUP) && pc_q[12];
  assign rsp_discard     = resetn && dok_disc_s;
  assign fetch_valid     = fetch_valid_q;
  assign fetch_pc        = fetch_pc_q;
  assign fetch_cnt       = fetch_cnt_q;
  assign fetch_ex        = fetch_ex_q;

  pre_if_fetch_gen_chk u_chk (
    .clk            (clk),
    .resetn         (resetn),
    .icache_data_ok (icache_data_ok),
    .out_q          (out_q),
    .disc_q         (disc_q),
    .max_out        (MAX_OUT)
  );

endmodule

// Protocol checker: in-flight bound and no response without a matching request.
module pre_if_fetch_gen_chk (
  input logic       clk,
  input logic       resetn,
  input logic       icache_data_ok,
  input logic [2:0] out_q,
  input logic [7:0] disc_q,
  input logic [2:0] max_out
);
  outstanding_bound: assert property (@(posedge clk) disable iff (!resetn) out_q <= max_out);
  no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    icache_data_ok |-> ((out_q != 3'd0) || (disc_q != 8'd0)));
endmodule

// File: tb/tb_pre_if_fetch_gen.sv
// Bench for pre_if_fetch_gen: directed scenarios plus random traffic, all checked
// cycle by cycle against a timestamp-based reference model of the fetch stage.
module tb_pre_if_fetch_gen;
  localparam logic [31:0] PC_START = 32'hBFC00000;
  localparam int FETCH_W = 2;
  localparam int MAX_OUT = 2;
  localparam int TLB_LAT = 2;
  localparam int BLK     = 4 * FETCH_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, exception_flush, eret_flush, refetch_flush, br_redirect, pred_taken;
  logic [31:0] ex_addr, epc, refetch_pc, br_target, pred_target;
  logic        IF_allowin, icache_addr_ok, icache_data_ok, s0_found, s0_v;
  logic [19:0] s0_pfn;
  logic [2:0]  s0_c, k0;
  logic        icache_valid, icache_uncached, s0_odd_page, fetch_valid, rsp_discard;
  logic [31:0] icache_addr, fetch_pc;
  logic [18:0] s0_vpn2;
  logic [2:0]  fetch_cnt, fetch_ex;

  pre_if_fetch_gen #(.PC_START(PC_START), .FETCH_W(FETCH_W), .MAX_OUTSTANDING(MAX_OUT),
                     .TLB_LAT(TLB_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .exception_flush(exception_flush), .ex_addr(ex_addr),
    .eret_flush(eret_flush), .epc(epc),
    .refetch_flush(refetch_flush), .refetch_pc(refetch_pc),
    .br_redirect(br_redirect), .br_target(br_target),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .IF_allowin(IF_allowin),
    .icache_valid(icache_valid), .icache_addr(icache_addr), .icache_uncached(icache_uncached),
    .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_found(s0_found), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_v(s0_v), .k0(k0),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_cnt(fetch_cnt),
    .fetch_ex(fetch_ex), .rsp_discard(rsp_discard)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the PC, the cycle from which it is ready, and request counts.
  logic [31:0] m_pc = 32'd0;
  int          m_cyc = 0, m_rdy = 0, m_live = 0, m_cancel = 0;
  bit          m_hold = 1'b0, m_known = 1'b0;
  logic        m_fv = 1'b0;
  logic [31:0] m_fpc = 32'd0;
  logic [2:0]  m_fcnt = 3'd0, m_fex = 3'd0;

  logic        o_valid, o_disc, o_fv;
  logic [31:0] o_addr, o_fpc;
  logic [2:0]  o_fcnt, o_fex;

  function automatic bit is_mapped(input logic [31:0] a);
    return a[31:30] != 2'b10;
  endfunction

  function automatic int ready_delay(input logic [31:0] a);
    return (is_mapped(a) && a[1:0] == 2'b00) ? 1 + TLB_LAT : 0;
  endfunction

  function automatic logic [2:0] exc_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 3'b100;
    if (is_mapped(a) && !s0_found) return 3'b010;
    if (is_mapped(a) && !s0_v) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {3'b100, r[28:2], 2'b00};
      1:       return {3'b101, r[28:2], 2'b00};
      2:       return {1'b0, r[30:2], 2'b00};
      3:       return {2'b11, r[29:2], 2'b00};
      4:       return {3'b100, r[28:0]};
      default: return {24'h800000, r[7:0]};
    endcase
  endfunction

  task automatic clear_flush();
    exception_flush = 1'b0; eret_flush = 1'b0; refetch_flush = 1'b0; br_redirect = 1'b0;
  endtask

  function automatic int pending();
    return m_live + m_cancel;
  endfunction

  // Inputs are already set; compare, clock once, advance the model.
  task automatic eval_and_step();
    logic        flush, e_valid, e_unc, e_disc, lookup;
    logic [31:0] tgt, paddr;
    logic [2:0]  ex;
    bit          rdy, fire, take;
    #1;
    flush = exception_flush | eret_flush | refetch_flush | br_redirect;
    tgt = exception_flush ? ex_addr : eret_flush ? epc : refetch_flush ? refetch_pc : br_target;
    rdy = resetn && !m_hold && (m_cyc >= m_rdy);
    ex = exc_of(m_pc);
    e_valid = rdy && IF_allowin && (m_live < MAX_OUT) && !flush && (ex == 3'b000);
    paddr = is_mapped(m_pc) ? {s0_pfn, m_pc[11:0]} : {3'b000, m_pc[28:0]};
    paddr = (paddr / BLK) * BLK;
    e_unc = is_mapped(m_pc) ? (s0_c != 3'd3) : (m_pc[31:29] == 3'b101 || k0 != 3'd3);
    e_disc = resetn && icache_data_ok && (m_cancel > 0);
    lookup = resetn && (ready_delay(m_pc) > 0) && (m_cyc + TLB_LAT >= m_rdy) && (m_cyc < m_rdy);

    check_val("icache_valid", icache_valid, e_valid);
    check_val("icache_addr", icache_addr, e_valid ? paddr : 32'd0);
    check_val("icache_uncached", icache_uncached, e_valid && e_unc);
    check_val("rsp_discard", rsp_discard, e_disc);
    check_val("s0_vpn2", s0_vpn2, lookup ? m_pc[31:13] : 19'd0);
    if (m_known) begin
      check_val("fetch_valid", fetch_valid, m_fv);
      check_val("fetch_pc", fetch_pc, m_fpc);
      check_val("fetch_cnt", fetch_cnt, m_fcnt);
      check_val("fetch_ex", fetch_ex, m_fex);
    end
    o_valid = icache_valid; o_addr = icache_addr; o_disc = rsp_discard;
    o_fv = fetch_valid; o_fpc = fetch_pc; o_fcnt = fetch_cnt; o_fex = fetch_ex;

    fire = e_valid && icache_addr_ok;
    take = rdy && (ex != 3'b000) && IF_allowin && !flush;
    @(posedge clk);
    m_cyc++;
    if (!resetn) begin
      m_pc = PC_START; m_rdy = m_cyc; m_hold = 1'b0; m_live = 0; m_cancel = 0;
      m_fv = 1'b0; m_fpc = 32'd0; m_fcnt = 3'd0; m_fex = 3'd0; m_known = 1'b1;
    end else begin
      if (icache_data_ok) begin
        if (m_cancel > 0) m_cancel--;
        else if (m_live > 0) m_live--;
      end
      if (fire) m_live++;
      if (flush) begin
        m_cancel += m_live;
        m_live = 0;
      end
      m_fv = fire || take;
      if (fire) begin
        m_fpc = m_pc; m_fcnt = 3'(FETCH_W - (m_pc % BLK) / 4); m_fex = 3'b000;
      end else if (take) begin
        m_fpc = m_pc; m_fcnt = 3'd1; m_fex = ex;
      end
      if (flush) begin
        m_pc = tgt; m_hold = 1'b0; m_rdy = m_cyc + ready_delay(tgt);
      end else if (fire) begin
        m_pc = pred_taken ? pred_target : (m_pc / BLK) * BLK + BLK;
        m_rdy = m_cyc + ready_delay(m_pc);
      end else if (take) begin
        m_hold = 1'b1;
      end
    end
    #1;
  endtask

  task automatic auto_step();
    icache_data_ok = (pending() > 0);
    eval_and_step();
  endtask

  logic [31:0] fa[3];
  logic [31:0] fp[2];
  logic [2:0]  fc[2];
  logic        dsc[3];
  int nf, nv, d, bad;

  initial begin
    resetn = 1'b0; clear_flush(); pred_taken = 1'b0;
    ex_addr = 32'd0; epc = 32'd0; refetch_pc = 32'd0; br_target = 32'd0; pred_target = 32'd0;
    IF_allowin = 1'b0; icache_addr_ok = 1'b0; icache_data_ok = 1'b0;
    s0_found = 1'b1; s0_v = 1'b1; s0_pfn = 20'd0; s0_c = 3'd3; k0 = 3'd3;
    fa = '{default: 32'd0}; fp = '{default: 32'd0}; fc = '{default: 3'd0};
    dsc = '{default: 1'b0};

    repeat (3) eval_and_step();
    check_val("rst_icache_valid", icache_valid, 1'b0);
    check_val("rst_fetch_valid", fetch_valid, 1'b0);

    // Sequential kseg1 fetch from the reset vector.
    resetn = 1'b1; IF_allowin = 1'b1; icache_addr_ok = 1'b1;
    nf = 0; bad = 0;
    for (int i = 0; i < 12 && nf < 3; i++) begin
      auto_step();
      if (o_fv && o_fcnt != 3'd2) bad++;
      if (o_valid) begin fa[nf] = o_addr; nf++; end
    end
    check_val("seq_fires", nf, 3);
    check_val("seq_addr0", fa[0], 32'h1FC00000);
    check_val("seq_addr1", fa[1], 32'h1FC00008);
    check_val("seq_addr2", fa[2], 32'h1FC00010);
    check_val("seq_cnt_not2", bad, 0);

    // Branch redirect into the middle of a block.
    br_redirect = 1'b1; br_target = 32'h80000014;
    auto_step();
    clear_flush();
    nv = 0;
    for (int i = 0; i < 12 && nv < 2; i++) begin
      auto_step();
      if (o_fv) begin fp[nv] = o_fpc; fc[nv] = o_fcnt; nv++; end
    end
    check_val("br_pc0", fp[0], 32'h80000014);
    check_val("br_cnt0", fc[0], 3'd1);
    check_val("br_pc1", fp[1], 32'h80000018);
    check_val("br_cnt1", fc[1], 3'd2);

    // Mapped fetch with a TLB hit.
    s0_found = 1'b1; s0_v = 1'b1; s0_pfn = 20'h12345; s0_c = 3'd3;
    exception_flush = 1'b1; ex_addr = 32'h00400000;
    auto_step();
    clear_flush();
    d = 0;
    for (int i = 0; i < 10; i++) begin
      auto_step();
      if (o_valid) break;
      d++;
    end
    check_val("map_delay", d, 3);
    check_val("map_addr", o_addr, 32'h12345000);

    // Mapped fetch with a TLB miss: refill exception, then PC holds.
    s0_found = 1'b0;
    exception_flush = 1'b1; ex_addr = 32'h00400000;
    auto_step();
    clear_flush();
    for (int i = 0; i < 10; i++) begin
      auto_step();
      if (o_fv) break;
    end
    check_val("refill_ex", o_fex, 3'b010);
    check_val("refill_cnt", o_fcnt, 3'd1);
    check_val("refill_pc", o_fpc, 32'h00400000);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      auto_step();
      if (o_valid || o_fv) nv++;
    end
    check_val("refill_hold", nv, 0);

    // Outstanding limit and response cancellation.
    s0_found = 1'b1;
    exception_flush = 1'b1; ex_addr = 32'h80001000; icache_addr_ok = 1'b0;
    auto_step();
    clear_flush();
    for (int i = 0; i < 10 && pending() > 0; i++) auto_step();
    icache_addr_ok = 1'b1; icache_data_ok = 1'b0;
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      eval_and_step();
      if (o_valid) nf++;
    end
    check_val("max_out_fires", nf, 2);
    check_val("max_out_stall", o_valid, 1'b0);
    exception_flush = 1'b1; ex_addr = 32'h80002000; icache_addr_ok = 1'b0;
    eval_and_step();
    clear_flush();
    icache_addr_ok = 1'b1;
    eval_and_step();
    check_val("post_flush_issue", o_valid, 1'b1);
    icache_addr_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      icache_data_ok = 1'b1;
      eval_and_step();
      dsc[k] = o_disc;
    end
    check_val("discard0", dsc[0], 1'b1);
    check_val("discard1", dsc[1], 1'b1);
    check_val("discard2", dsc[2], 1'b0);

    // Simultaneous exception and branch redirect; then a misaligned PC.
    icache_data_ok = 1'b0; icache_addr_ok = 1'b1;
    exception_flush = 1'b1; ex_addr = 32'h80000100;
    br_redirect = 1'b1; br_target = 32'h80000200;
    auto_step();
    clear_flush();
    auto_step();
    check_val("prio_addr", o_addr, 32'h00000100);
    exception_flush = 1'b1; ex_addr = 32'h80000002;
    auto_step();
    clear_flush();
    for (int i = 0; i < 8; i++) begin
      auto_step();
      if (o_fv && o_fex != 3'b000) break;
    end
    check_val("adel_ex", o_fex, 3'b100);
    check_val("adel_cnt", o_fcnt, 3'd1);

    // Random traffic, with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      resetn = !(i >= 750 && i < 752);
      IF_allowin = ($urandom_range(0, 9) < 8);
      icache_addr_ok = ($urandom_range(0, 9) < 7);
      icache_data_ok = resetn && (pending() > 0) && ($urandom_range(0, 1) == 1);
      exception_flush = ($urandom_range(0, 49) == 0);
      eret_flush = ($urandom_range(0, 49) == 0);
      refetch_flush = ($urandom_range(0, 49) == 0);
      br_redirect = ($urandom_range(0, 29) == 0);
      ex_addr = pick_addr(); epc = pick_addr(); refetch_pc = pick_addr(); br_target = pick_addr();
      pred_taken = ($urandom_range(0, 7) == 0);
      pred_target = pick_addr();
      if ($urandom_range(0, 19) == 0) k0 = 3'($urandom_range(0, 7));
      if (exception_flush || eret_flush || refetch_flush || br_redirect) begin
        s0_found = ($urandom_range(0, 3) != 0);
        s0_v = ($urandom_range(0, 3) != 0);
        s0_pfn = 20'($urandom);
        s0_c = 3'($urandom_range(0, 7));
      end
      eval_and_step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
